rsp_s1_prep_ahbic_decode_mux: RTL

// - Slave-side address decoder and response multiplexer for one AHB layer of the rsp_s1_prep interconnect.
// - Decodes HADDR into per-slave selects plus a default-slave select (HSELDEF), which drives the default slave.
// - Registers the data-phase owner and muxes HRDATA/HREADYOUT/HRESP back from the selected slave or the default slave.
// - Optional watchdog ends hung data phases with a two-cycle ERROR.

---
 rtl/rsp_s1_prep_ahbic_decode_mux.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/rsp_s1_prep_ahbic_decode_mux.sv
// Address decoder and response mux for one AHB layer of the rsp_s1_prep interconnect.
// Defining RSP_S1_PREP_AHBIC_TIMEOUT_EN adds a watchdog that ends hung data phases with ERROR.
module rsp_s1_prep_ahbic_decode_mux #(
    parameter int unsigned                 NUM_SLV     = 4,
    parameter int unsigned                 ADDR_W      = 32,
    parameter int unsigned                 DATA_W      = 32,
    parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_BASE    = '0,
    parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_MASK    = '0,
    parameter int unsigned                 TIMEOUT_CYC = 256
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic                        HSEL,
    input  logic [ADDR_W-1:0]           HADDR,
    input  logic [1:0]                  HTRANS,
    input  logic                        HREADY,
    output logic [NUM_SLV-1:0]          HSELS,
    output logic                        HSELDEF,
    input  logic [NUM_SLV-1:0]          HREADYOUTS,
    input  logic [2*NUM_SLV-1:0]        HRESPS,
    input  logic [DATA_W*NUM_SLV-1:0]   HRDATAS,
    input  logic                        HREADYOUTDEF,
    input  logic [1:0]                  HRESPDEF,
    output logic                        HREADYOUT,
    output logic [1:0]                  HRESP,
    output logic [DATA_W-1:0]           HRDATA
);

    localparam int unsigned SEL_W = NUM_SLV + 1;

    logic [NUM_SLV-1:0] hung;
    logic [NUM_SLV-1:0] sels;
    logic               hit;
    logic [SEL_W-1:0]   dsel_q;
    logic               mux_rdy;
    logic [1:0]         mux_resp;
    logic [DATA_W-1:0]  mux_data;

    // Selects depend only on region match, not on transfer type.
    logic unused_htrans;
    assign unused_htrans = ^HTRANS;

    // Lowest matching index owns the address; a hung owner's region falls to the default slave.
    always_comb begin
        sels = '0;
        hit  = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (!hit && ((HADDR & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
                hit     = 1'b1;
                sels[i] = HSEL & ~hung[i];
            end
        end
    end

    assign HSELS   = sels;
    assign HSELDEF = HSEL & ~|sels;

    // Data-phase owner advances only when the bus is ready.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel_q <= '0;
        end else if (HREADY) begin
            dsel_q <= {HSELDEF, sels};
        end
    end

    always_comb begin
        mux_rdy  = 1'b1;
        mux_resp = 2'b00;
        mux_data = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (dsel_q[i]) begin
                mux_rdy  = HREADYOUTS[i];
                mux_resp = HRESPS[2*i +: 2];
                mux_data = HRDATAS[i*DATA_W +: DATA_W];
            end
        end
        if (dsel_q[NUM_SLV]) begin
            mux_rdy  = HREADYOUTDEF;
            mux_resp = HRESPDEF;
        end
    end

`ifdef RSP_S1_PREP_AHBIC_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {WD_IDLE, WD_COUNT, WD_ERR1, WD_ERR2} wd_state_t;

    wd_state_t          wd_state;
    logic [CNT_W-1:0]   cnt;
    logic               stall;
    logic               timeout;

    // Only decoded slaves are watched; the default slave may stall indefinitely.
    assign stall   = (|dsel_q[NUM_SLV-1:0]) & ~(|(dsel_q[NUM_SLV-1:0] & HREADYOUTS));
    assign timeout = (wd_state == WD_COUNT) && stall && (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wd_state <= WD_IDLE;
            cnt      <= '0;
        end else begin
            case (wd_state)
                WD_IDLE: begin
                    if (stall) begin
                        wd_state <= WD_COUNT;
                        cnt      <= CNT_W'(1);
                    end
                end
                WD_COUNT: begin
                    if (!stall) begin
                        wd_state <= WD_IDLE;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (timeout) wd_state <= WD_ERR1;
                    end
                end
                WD_ERR1: wd_state <= WD_ERR2;
                WD_ERR2: begin
                    wd_state <= WD_IDLE;
                    cnt      <= '0;
                end
                default: wd_state <= WD_IDLE;
            endcase
        end
    end

    // Set on timeout of the owner; cleared once that slave finally reports ready.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hung <= '0;
        end else begin
            hung <= (hung & ~HREADYOUTS) | (timeout ? dsel_q[NUM_SLV-1:0] : '0);
        end
    end

    always_comb begin
        HREADYOUT = mux_rdy;
        HRESP     = mux_resp;
        HRDATA    = mux_data;
        if (wd_state == WD_ERR1) begin
            HREADYOUT = 1'b0;
            HRESP     = 2'b01;
            HRDATA    = '0;
        end else if (wd_state == WD_ERR2) begin
            HREADYOUT = 1'b1;
            HRESP     = 2'b01;
            HRDATA    = '0;
        end
    end
`else
    localparam int unsigned UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;

    assign hung      = '0;
    assign HREADYOUT = mux_rdy;
    assign HRESP     = mux_resp;
    assign HRDATA    = mux_data;
`endif

endmodule
